// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Optional trailing XOR checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6,
    ST_CHK   = 3'd7
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian word assembler: inserts one byte per load at the running index.
// o_full flags that the byte being loaded now completes the word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clear,
  input  logic                      i_load,
  input  logic [7:0]                i_data,
  output logic [8*WORD_BYTES-1:0]   o_word,
  output logic                      o_full
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0]        r_idx;
  logic [8*WORD_BYTES-1:0] r_buf;

  // Clearing wipes the buffer too, so an abandoned load leaves no stale bytes.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (i_load) begin
      r_buf[{r_idx, 3'b000} +: 8] <= i_data;
      r_idx                       <= r_idx + IDX_W'(1);
    end
  end

  assign o_word = r_buf;
  assign o_full = (r_idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader writing 32-bit words to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte over all data bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  state_t                   r_state;
  logic                     r_rxReady;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_memWe;
  logic [3:0]               r_memSel;
  logic                     r_cpuHold;
  logic                     r_done;
  logic                     r_err;
  logic [ADDR_W:0]          r_words;
  logic [8*LEN_BYTES-1:0]   r_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]               r_xor;
`endif

  logic                     w_xfer;
  logic                     w_pkClear;
  logic                     w_pkLoad;
  logic                     w_pkFull;
  logic [31:0]              w_word;
  logic [8*LEN_BYTES-1:0]   w_lenFull;
  logic [ADDR_W:0]          w_wordsNext;
  logic                     w_lastWord;

  assign w_xfer      = rx_valid && r_rxReady;
  assign w_pkLoad    = w_xfer && (r_state == ST_DATA);
  assign w_pkClear   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_lenFull   = {rx_data, r_len[7:0]};
  assign w_wordsNext = r_words + (ADDR_W + 1)'(1);
  assign w_lastWord  = (32'(w_wordsNext) == 32'(r_len));

  byte_packer u_packer (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clear (w_pkClear),
    .i_load  (w_pkLoad),
    .i_data  (rx_data),
    .o_word  (w_word),
    .o_full  (w_pkFull)
  );

  // Every output is a register updated alongside the state, so rx_ready never
  // depends combinationally on rx_valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_rxReady <= 1'b0;
      r_addr    <= '0;
      r_memWe   <= 1'b0;
      r_memSel  <= 4'b0000;
      r_cpuHold <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_words   <= '0;
      r_len     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor     <= 8'h00;
`endif
    end else begin
      r_memWe  <= 1'b0;
      r_memSel <= 4'b0000;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state   <= ST_HDR0;
            r_rxReady <= 1'b1;
            r_cpuHold <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_words   <= '0;
            r_addr    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= 8'h00;
`endif
          end
        end
        ST_HDR0: begin
          if (w_xfer) begin
            r_len[7:0] <= rx_data;
            r_state    <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_xfer) begin
            r_len <= w_lenFull;
            if (w_lenFull == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state   <= ST_CHK;
`else
              r_state   <= ST_DONE;
              r_rxReady <= 1'b0;
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
`endif
            end else if (32'(w_lenFull) > 32'(MAX_WORDS)) begin
              r_state   <= ST_ERR;
              r_rxReady <= 1'b0;
              r_err     <= 1'b1;
            end else begin
              r_state <= ST_DATA;
              r_addr  <= '0;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ rx_data;
`endif
            if (w_pkFull) begin
              r_state   <= ST_WRITE;
              r_rxReady <= 1'b0;
              r_memWe   <= 1'b1;
              r_memSel  <= SEL_ALL;
            end
          end
        end
        ST_WRITE: begin
          r_words <= w_wordsNext;
          if (w_lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state   <= ST_CHK;
            r_rxReady <= 1'b1;
`else
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_cpuHold <= 1'b0;
`endif
          end else begin
            r_addr    <= r_addr + ADDR_W'(1);
            r_state   <= ST_DATA;
            r_rxReady <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_xfer) begin
            r_rxReady <= 1'b0;
            if (rx_data == r_xor) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state   <= ST_IDLE;
          r_rxReady <= 1'b0;
          r_cpuHold <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready     = r_rxReady;
  assign mem_addr     = r_addr;
  assign mem_din      = w_word;
  assign mem_we       = r_memWe;
  assign mem_sel      = r_memSel;
  assign cpu_hold     = r_cpuHold;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum scenarios run only when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  int          nChecks = 0;
  int          nPass   = 0;
  int          selBad  = 0;
  logic [7:0]  tbXor   = 8'h00;
  logic [9:0]  wrAddr[$];
  logic [31:0] wrData[$];

  imem_loader dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write-port monitor sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_din);
    end
    if (mem_sel !== ((mem_we === 1'b1) ? 4'b1111 : 4'b0000)) selBad++;
  end

  task automatic doReset();
    RST = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (rx_ready === 1'b1) begin
        @(posedge CLK);
        #1 ok = 1'b1;
      end
    end
    rx_valid = 1'b0;
    tbXor = tbXor ^ b;
    if (!ok) begin
      nChecks++;
      $display("[TB] FAIL byte_timeout: byte %02h not taken, rx_ready=%b required 1", b, rx_ready);
    end
  endtask

  task automatic sendGap(input logic [7:0] b);
    int g;
    g = 1 + $urandom_range(0, 7);
    rx_valid = 1'b0;
    repeat (g) @(posedge CLK);
    #1 sendByte(b);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clearWrites();
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    start = 1'b0;
    nChecks++;
    if ({rx_ready, mem_we, cpu_hold, done, err} !== 5'b0) $display("[TB] FAIL reset_flags: got %b required 00000", {rx_ready, mem_we, cpu_hold, done, err});
    else nPass++;
    nChecks++;
    if ({mem_sel, words_loaded, mem_addr} !== 25'd0) $display("[TB] FAIL reset_counters: sel=%h words=%0d addr=%0d required all 0", mem_sel, words_loaded, mem_addr);
    else nPass++;
    nChecks++;
    if (mem_din !== 32'h0) $display("[TB] FAIL reset_din: got %h required 00000000", mem_din);
    else nPass++;
    waitCycles(2);
    nChecks++;
    if ({cpu_hold, rx_ready} !== 2'b00) $display("[TB] FAIL reset_wins_start: hold/ready=%b required 00", {cpu_hold, rx_ready});
    else nPass++;
  endtask

  task automatic test_two_words();
    clearWrites();
    pulseStart();
    nChecks++;
    if ({cpu_hold, rx_ready} !== 2'b11) $display("[TB] FAIL start_hold: hold/ready=%b required 11", {cpu_hold, rx_ready});
    else nPass++;
    sendByte(8'h02); sendByte(8'h00);
    tbXor = 8'h00;
    sendByte(8'h13); sendByte(8'h05);
    pulseStart();
    sendByte(8'h00); sendByte(8'h00);
    nChecks++;
    if ({mem_we, mem_addr, mem_din} !== {1'b1, 10'd0, 32'h00000513}) $display("[TB] FAIL write_latency: we=%b addr=%0d din=%h required 1/0/00000513", mem_we, mem_addr, mem_din);
    else nPass++;
    sendByte(8'h73); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(8'h65);
`endif
    waitCycles(2);
    nChecks++;
    if (wrAddr.size() != 2 || wrAddr[0] !== 10'd0 || wrData[0] !== 32'h00000513) $display("[TB] FAIL two_word0: count=%0d required 2 with addr0=00000513", wrAddr.size());
    else nPass++;
    nChecks++;
    if (wrAddr.size() != 2 || wrAddr[1] !== 10'd1 || wrData[1] !== 32'h00000073) $display("[TB] FAIL two_word1: count=%0d required 2 with addr1=00000073", wrAddr.size());
    else nPass++;
    nChecks++;
    if ({done, cpu_hold, err, rx_ready, words_loaded} !== {4'b1000, 11'd2}) $display("[TB] FAIL two_done: done/hold/err/ready=%b words=%0d required 1000/2", {done, cpu_hold, err, rx_ready}, words_loaded);
    else nPass++;
  endtask

  task automatic test_zero_len();
    bit gotDone;
    clearWrites();
    pulseStart();
    nChecks++;
    if ({done, rx_ready, cpu_hold} !== 3'b011) $display("[TB] FAIL restart_from_done: done/ready/hold=%b required 011", {done, rx_ready, cpu_hold});
    else nPass++;
    sendByte(8'h00); sendByte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(8'h00);
`endif
    gotDone = (done === 1'b1);
    for (int i = 0; i < 3 && !gotDone; i++) begin
      waitCycles(1);
      gotDone = (done === 1'b1);
    end
    nChecks++;
    if (!gotDone) $display("[TB] FAIL zero_len_done: done=%b required 1 within 3 cycles", done);
    else nPass++;
    waitCycles(2);
    nChecks++;
    if (wrAddr.size() != 0 || words_loaded !== 11'd0 || cpu_hold !== 1'b0) $display("[TB] FAIL zero_len_nowrite: writes=%0d words=%0d hold=%b required 0/0/0", wrAddr.size(), words_loaded, cpu_hold);
    else nPass++;
  endtask

  task automatic test_oversize();
    clearWrites();
    pulseStart();
    sendByte(8'h01); sendByte(8'h04);
    nChecks++;
    if ({err, cpu_hold, rx_ready, done} !== 4'b1100) $display("[TB] FAIL oversize_err: err/hold/ready/done=%b required 1100", {err, cpu_hold, rx_ready, done});
    else nPass++;
    waitCycles(3);
    pulseStart();
    nChecks++;
    if ({err, rx_ready, cpu_hold, wrAddr.size() != 0} !== 4'b0110) $display("[TB] FAIL err_restart: err/ready/hold/anywrite=%b required 0110", {err, rx_ready, cpu_hold, wrAddr.size() != 0});
    else nPass++;
    doReset();
  endtask

  task automatic test_gaps();
    clearWrites();
    pulseStart();
    sendGap(8'h01); sendGap(8'h00);
    tbXor = 8'h00;
    sendGap(8'hEF); sendGap(8'hBE); sendGap(8'hAD); sendGap(8'hDE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendGap(8'h22);
`endif
    waitCycles(2);
    nChecks++;
    if (wrAddr.size() != 1 || wrAddr[0] !== 10'd0 || wrData[0] !== 32'hDEADBEEF) $display("[TB] FAIL gap_word: count=%0d required 1 with addr0=DEADBEEF", wrAddr.size());
    else nPass++;
    nChecks++;
    if ({done, err, words_loaded} !== {2'b10, 11'd1}) $display("[TB] FAIL gap_done: done/err=%b words=%0d required 10/1", {done, err}, words_loaded);
    else nPass++;
  endtask

  task automatic test_reset_mid_load();
    clearWrites();
    pulseStart();
    sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    nChecks++;
    if ({cpu_hold, rx_ready, done, mem_din} !== 35'd0) $display("[TB] FAIL midload_reset: hold/ready/done=%b din=%h required 000/0", {cpu_hold, rx_ready, done}, mem_din);
    else nPass++;
    pulseStart();
    sendByte(8'h01); sendByte(8'h00);
    tbXor = 8'h00;
    sendByte(8'h78); sendByte(8'h56); sendByte(8'h34); sendByte(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(8'h08);
`endif
    waitCycles(2);
    nChecks++;
    if (wrAddr.size() != 1 || wrAddr[0] !== 10'd0 || wrData[0] !== 32'h12345678) $display("[TB] FAIL midload_reload: count=%0d required 1 with addr0=12345678", wrAddr.size());
    else nPass++;
  endtask

  task automatic test_max_len();
    int bad;
    logic [9:0] idx;
    clearWrites();
    pulseStart();
    sendByte(8'h00); sendByte(8'h04);
    tbXor = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      idx = 10'(i);
      sendByte(idx[7:0]);
      sendByte({6'b0, idx[9:8]});
      sendByte(8'hA5);
      sendByte(8'h3C);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(tbXor);
`endif
    waitCycles(2);
    bad = 0;
    for (int i = 0; i < wrAddr.size(); i++) begin
      idx = 10'(i);
      if (wrAddr[i] !== idx || wrData[i] !== {8'h3C, 8'hA5, 6'b0, idx}) bad++;
    end
    nChecks++;
    if (wrAddr.size() != 1024 || bad != 0) $display("[TB] FAIL max_len_writes: count=%0d bad=%0d required 1024/0", wrAddr.size(), bad);
    else nPass++;
    nChecks++;
    if (wrAddr.size() != 1024 || wrAddr[1023] !== 10'd1023) $display("[TB] FAIL max_len_last_addr: count=%0d required last addr 1023", wrAddr.size());
    else nPass++;
    nChecks++;
    if ({done, err, cpu_hold, words_loaded} !== {3'b100, 11'd1024}) $display("[TB] FAIL max_len_done: done/err/hold=%b words=%0d required 100/1024", {done, err, cpu_hold}, words_loaded);
    else nPass++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clearWrites();
    pulseStart();
    sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    waitCycles(1);
    nChecks++;
    if ({rx_ready, done} !== 2'b10) $display("[TB] FAIL chk_wait: ready/done=%b required 10", {rx_ready, done});
    else nPass++;
    sendByte(8'h04);
    waitCycles(1);
    nChecks++;
    if ({done, err} !== 2'b10 || wrAddr.size() != 1 || wrData[0] !== 32'h04030201) $display("[TB] FAIL chk_good: done/err=%b writes=%0d required 10/1 with 04030201", {done, err}, wrAddr.size());
    else nPass++;
    clearWrites();
    pulseStart();
    sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    sendByte(8'h05);
    waitCycles(1);
    nChecks++;
    if ({done, err, cpu_hold} !== 3'b011 || wrAddr.size() != 1) $display("[TB] FAIL chk_bad: done/err/hold=%b writes=%0d required 011/1", {done, err, cpu_hold}, wrAddr.size());
    else nPass++;
  endtask
`endif

  initial begin
    RST = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #1;
    test_reset();
    test_two_words();
    test_zero_len();
    test_oversize();
    test_gaps();
    test_reset_mid_load();
    test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    nChecks++;
    if (selBad != 0) $display("[TB] FAIL mem_sel_track: %0d bad cycles, required 0", selBad);
    else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
